des_sbox_compress: RTL

- Back end of the DES round function: takes the 48-bit key-mixed word (expanded R XOR subkey) and compresses it to 32 bits.
- Substitution uses S-boxes S1..S8, followed by the P permutation (FIPS 46-3 tables).
- Evaluates LANES S-boxes per cycle in an iterative datapath, with valid/ready handshakes on both sides.
- Sits between the subkey XOR stage and the L/R swap in the round controller.

---
 rtl/des_sbox_compress.sv | 138 +++++++++++++
 1 files changed

// File: rtl/des_sbox_compress.sv
// DES round back end: 48-bit key-mixed word -> S1..S8 substitution -> P permutation.
// Iterative datapath evaluating LANES S-boxes per clock, valid/ready on both sides.
module des_sbox_compress #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] sbox_data,
    output logic        busy
);
    localparam int         STEPS = 8 / LANES;
    localparam logic [3:0] LAST  = 4'(STEPS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
        $error("des_sbox_compress: LANES must be 1, 2, 4 or 8");
    end

    // S1..S8, each 64 nibbles laid out row-major (row*16 + column), entry 0 in the top nibble.
    localparam logic [2047:0] SBOX_ALL = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // P table with DES positions made zero-based, output bit 1 first.
    localparam logic [159:0] P_IDX = {
        5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
        5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
        5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
        5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
    };

    logic [1:0]         state_reg;
    logic [47:0]        sh_reg;
    logic [31:0]        acc_reg;
    logic [3:0]         cnt_reg;
    logic [31:0]        out_data_reg;
    logic [31:0]        sbox_data_reg;

    logic [4*LANES-1:0] lane_out;
    logic [47:0]        sh_next;
    logic [31:0]        acc_next;
    logic [31:0]        perm_out;

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [5:0]  grp;
        logic [2:0]  box;
        logic [5:0]  idx;
        logic [10:0] pos;
        assign grp = sh_reg[47-6*gi -: 6];
        assign box = cnt_reg[2:0] * 3'(LANES) + 3'(gi);
        // row = {b1,b6}, column = {b2..b5}
        assign idx = {grp[5], grp[0], grp[4:1]};
        assign pos = 11'd2047 - {box, 8'd0} - {3'd0, idx, 2'd0};
        assign lane_out[4*(LANES-gi)-1 -: 4] = SBOX_ALL[pos -: 4];
    end

    if (LANES == 8) begin : g_full
        assign sh_next  = '0;
        assign acc_next = lane_out;
    end else begin : g_part
        assign sh_next  = {sh_reg[47-6*LANES:0], {6*LANES{1'b0}}};
        assign acc_next = {acc_reg[31-4*LANES:0], lane_out};
    end

    for (gi = 0; gi < 32; gi++) begin : g_perm
        localparam int SRC = 31 - int'(P_IDX[159-5*gi -: 5]);
        assign perm_out[31-gi] = acc_reg[SRC];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sh_reg        <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            sbox_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sh_reg    <= in_data;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // The extra step after the last shift publishes the finished accumulator.
                    if (cnt_reg == LAST) begin
                        out_data_reg  <= perm_out;
                        sbox_data_reg <= acc_reg;
                        state_reg     <= DONE;
                    end else begin
                        sh_reg  <= sh_next;
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            sh_reg    <= in_data;
                            cnt_reg   <= '0;
                            state_reg <= RUN;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) || (state_reg == DONE && out_ready);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == RUN);
    assign out_data  = out_data_reg;
    assign sbox_data = sbox_data_reg;

endmodule
